// File: rtl/mux_arb_4to1_pkg.sv
// Shared lane constants and grant helper for the
// 4-lane merge arbiter and its downstream demux.
package mux_arb_4to1_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_WIDTH = 8;

  typedef logic [LANE_W-1:0] lane_t;

  typedef struct packed {
    logic  hit;
    lane_t lane;
  } grant_t;

  // Round-robin pick: first non-empty lane after last.
  // Walks offsets high to low so the nearest one wins;
  // offset NUM_LANES lands on last itself (lowest rank).
  function automatic grant_t rr_pick(
    input lane_t                 last,
    input logic [NUM_LANES-1:0] ne
  );
    grant_t g;
    lane_t  c;
    g.hit  = 1'b0;
    g.lane = last;
    for (int i = NUM_LANES; i >= 1; i--) begin
      c = last + lane_t'(i);
      if (ne[c]) begin
        g.hit  = 1'b1;
        g.lane = c;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mux_arb_4to1_fifo_lane.sv
// Per-lane synchronous FIFO, power-of-two depth,
// pointers wrap naturally at DEPTH.
module fifo_lane
  import mux_arb_4to1_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mux_arb_4to1.sv
// Four byte lanes merged round-robin into one
// registered output slice with valid/ready flow control.
module mux_arb_4to1
  import mux_arb_4to1_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Entrada0,
  input  logic [WIDTH-1:0] Entrada1,
  input  logic [WIDTH-1:0] Entrada2,
  input  logic [WIDTH-1:0] Entrada3,
  input  logic             validEntrada0,
  input  logic             validEntrada1,
  input  logic             validEntrada2,
  input  logic             validEntrada3,
  output logic             full0,
  output logic             full1,
  output logic             full2,
  output logic             full3,
  output logic             overflow0,
  output logic             overflow1,
  output logic             overflow2,
  output logic             overflow3,
  output logic [WIDTH-1:0] Salida,
  output logic             validSalida,
  output logic [1:0]       laneSalida,
  input  logic             readySalida
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]     lane_din  [NUM_LANES];
  logic [WIDTH-1:0]     lane_dout [NUM_LANES];
  logic [CW-1:0]        lane_cnt  [NUM_LANES];
  logic [NUM_LANES-1:0] lane_valid;
  logic [NUM_LANES-1:0] lane_push;
  logic [NUM_LANES-1:0] lane_pop;
  logic [NUM_LANES-1:0] lane_full;
  logic [NUM_LANES-1:0] lane_empty;
  logic [NUM_LANES-1:0] lane_at_cap;
  logic [NUM_LANES-1:0] ovf_q;
  lane_t                last_grant;
  grant_t               gnt;
  logic                 load;

  assign lane_din[0] = Entrada0;
  assign lane_din[1] = Entrada1;
  assign lane_din[2] = Entrada2;
  assign lane_din[3] = Entrada3;

  assign lane_valid = {validEntrada3, validEntrada2,
                       validEntrada1, validEntrada0};

  assign lane_push = lane_valid & ~lane_full;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fifo_lane #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (lane_push[g]),
      .pop   (lane_pop[g]),
      .din   (lane_din[g]),
      .dout  (lane_dout[g]),
      .count (lane_cnt[g]),
      .full  (lane_full[g]),
      .empty (lane_empty[g])
    );
    assign lane_at_cap[g] = (lane_cnt[g] == CW'(DEPTH));
  end

  assign full0 = lane_at_cap[0];
  assign full1 = lane_at_cap[1];
  assign full2 = lane_at_cap[2];
  assign full3 = lane_at_cap[3];

  assign overflow0 = ovf_q[0];
  assign overflow1 = ovf_q[1];
  assign overflow2 = ovf_q[2];
  assign overflow3 = ovf_q[3];

  assign load = ~validSalida | readySalida;
  assign gnt  = rr_pick(last_grant, ~lane_empty);

  // Pop the granted lane only when the slice takes a byte.
  always_comb begin
    lane_pop = '0;
    if (load && gnt.hit && !reset) lane_pop[gnt.lane] = 1'b1;
  end

  // Sticky overflow: a push against a full lane is lost.
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= '0;
    else       ovf_q <= ovf_q | (lane_valid & lane_full);
  end

  // Output register slice plus round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      Salida      <= '0;
      validSalida <= 1'b0;
      laneSalida  <= '0;
      last_grant  <= lane_t'(NUM_LANES - 1);
    end else if (load) begin
      if (gnt.hit) begin
        Salida      <= lane_dout[gnt.lane];
        laneSalida  <= gnt.lane;
        validSalida <= 1'b1;
        last_grant  <= gnt.lane;
      end else begin
        validSalida <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_4to1.sv
// Directed scoreboard bench for the 4-lane merge
// arbiter: expected bytes queued, monitor compares.
module tb_mux_arb_4to1;

  logic       clk;
  logic       reset;
  logic [7:0] ent [4];
  logic [3:0] ven;
  logic [3:0] full;
  logic [3:0] ovf;
  logic [7:0] Salida;
  logic       validSalida;
  logic [1:0] laneSalida;
  logic       readySalida;

  logic [9:0] exp_q [$];
  logic [9:0] mon_e;
  int         n_chk = 0;
  int         n_err = 0;

  mux_arb_4to1 #(.DEPTH(4), .WIDTH(8)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .Entrada0      (ent[0]),
    .Entrada1      (ent[1]),
    .Entrada2      (ent[2]),
    .Entrada3      (ent[3]),
    .validEntrada0 (ven[0]),
    .validEntrada1 (ven[1]),
    .validEntrada2 (ven[2]),
    .validEntrada3 (ven[3]),
    .full0         (full[0]),
    .full1         (full[1]),
    .full2         (full[2]),
    .full3         (full[3]),
    .overflow0     (ovf[0]),
    .overflow1     (ovf[1]),
    .overflow2     (ovf[2]),
    .overflow3     (ovf[3]),
    .Salida        (Salida),
    .validSalida   (validSalida),
    .laneSalida    (laneSalida),
    .readySalida   (readySalida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(logic [7:0] d, logic [1:0] l);
    exp_q.push_back({l, d});
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, " Salida"}, 32'(Salida), 0);
    chk({tag, " valid"}, 32'(validSalida), 0);
    chk({tag, " lane"}, 32'(laneSalida), 0);
    chk({tag, " full"}, 32'(full), 0);
    chk({tag, " overflow"}, 32'(ovf), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ven = '0;
    readySalida = 1'b0;
    cyc();
    cyc();
    exp_q.delete();
    chk_reset_state("reset");
    reset = 1'b0;
  endtask

  task automatic drain(string tag);
    int n = 0;
    readySalida = 1'b1;
    while ((exp_q.size() != 0 || validSalida) && n < 50) begin
      cyc();
      n++;
    end
    chk({tag, " queue drained"}, 32'(exp_q.size()), 0);
    chk({tag, " idle valid"}, 32'(validSalida), 0);
  endtask

  // Scoreboard monitor: a byte is consumed on valid&ready.
  always @(negedge clk) begin
    if (!reset && validSalida && readySalida) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected output: got %0h lane %0d want none",
                 Salida, laneSalida);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb data", 32'(Salida), 32'(mon_e[7:0]));
        chk("sb lane", 32'(laneSalida), 32'(mon_e[9:8]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq [8];
    reset = 1'b1;
    ven = '0;
    readySalida = 1'b0;
    for (int i = 0; i < 4; i++) ent[i] = '0;

    // Single byte on lane 2, two-edge latency.
    do_reset();
    readySalida = 1'b1;
    ven[2] = 1'b1;
    ent[2] = 8'hA5;
    expect_out(8'hA5, 2);
    cyc();
    ven = '0;
    chk("t1 no bypass", 32'(validSalida), 0);
    cyc();
    chk("t1 valid", 32'(validSalida), 1);
    chk("t1 data", 32'(Salida), 32'hA5);
    chk("t1 lane", 32'(laneSalida), 2);
    cyc();
    chk("t1 valid drop", 32'(validSalida), 0);

    // Four lanes of two bytes each, round-robin order.
    do_reset();
    ven = 4'hF;
    ent[0] = 8'h10; ent[1] = 8'h20;
    ent[2] = 8'h30; ent[3] = 8'h40;
    cyc();
    ent[0] = 8'h11; ent[1] = 8'h21;
    ent[2] = 8'h31; ent[3] = 8'h41;
    cyc();
    ven = '0;
    seq = '{8'h10, 8'h20, 8'h30, 8'h40,
            8'h11, 8'h21, 8'h31, 8'h41};
    for (int k = 0; k < 8; k++) expect_out(seq[k], 2'(k % 4));
    readySalida = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t2 valid", 32'(validSalida), 1);
      chk("t2 data", 32'(Salida), 32'(seq[k]));
      cyc();
    end
    chk("t2 end valid", 32'(validSalida), 0);
    drain("t2");

    // Lane 1 overflow while the slice is stalled on 5F.
    do_reset();
    ven[0] = 1'b1;
    ent[0] = 8'h5F;
    expect_out(8'h5F, 0);
    cyc();
    ven = '0;
    cyc();
    chk("t3 held", 32'(Salida), 32'h5F);
    for (int i = 0; i < 5; i++) begin
      ven[1] = 1'b1;
      ent[1] = 8'(8'h50 + i);
      if (i < 4) expect_out(8'(8'h50 + i), 1);
      cyc();
      chk("t3 full1", 32'(full[1]), (i >= 3) ? 1 : 0);
      chk("t3 ovf1", 32'(ovf[1]), (i == 4) ? 1 : 0);
    end
    ven = '0;
    chk("t3 still held", 32'(Salida), 32'h5F);
    drain("t3");
    chk("t3 ovf sticky", 32'(ovf[1]), 1);
    chk("t3 full clear", 32'(full[1]), 0);

    // Stall hold with pushes on lanes 0 and 2.
    do_reset();
    ven[0] = 1'b1; ent[0] = 8'h60;
    ven[3] = 1'b1; ent[3] = 8'h63;
    cyc();
    ven = '0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      ven[0] = 1'b1; ent[0] = 8'(8'h80 + i);
      ven[2] = 1'b1; ent[2] = 8'(8'h70 + i);
      cyc();
      chk("t4 hold data", 32'(Salida), 32'h60);
      chk("t4 hold lane", 32'(laneSalida), 0);
      chk("t4 hold valid", 32'(validSalida), 1);
    end
    ven = '0;
    chk("t4 full0", 32'(full[0]), 1);
    chk("t4 full2", 32'(full[2]), 1);
    expect_out(8'h60, 0); expect_out(8'h70, 2);
    expect_out(8'h63, 3); expect_out(8'h80, 0);
    expect_out(8'h71, 2); expect_out(8'h81, 0);
    expect_out(8'h72, 2); expect_out(8'h82, 0);
    expect_out(8'h73, 2); expect_out(8'h83, 0);
    drain("t4");

    // Lane 3 at count 2: push and grant in the same cycle.
    do_reset();
    ven[3] = 1'b1;
    ent[3] = 8'h90;
    cyc();
    ent[3] = 8'h91;
    cyc();
    ent[3] = 8'h92;
    cyc();
    for (int i = 0; i < 6; i++) expect_out(8'(8'h90 + i), 3);
    readySalida = 1'b1;
    ent[3] = 8'h93;
    cyc();
    chk("t5 data", 32'(Salida), 32'h91);
    chk("t5 lane", 32'(laneSalida), 3);
    readySalida = 1'b0;
    ent[3] = 8'h94;
    cyc();
    chk("t5 full3 cnt3", 32'(full[3]), 0);
    ent[3] = 8'h95;
    cyc();
    chk("t5 full3 cnt4", 32'(full[3]), 1);
    ven = '0;
    drain("t5");

    // Mid-stream reset, then lane 0 wins over lane 2.
    do_reset();
    ven[1] = 1'b1; ent[1] = 8'hB1;
    ven[2] = 1'b1; ent[2] = 8'hB2;
    ven[3] = 1'b1; ent[3] = 8'hB3;
    cyc();
    ven = '0;
    ven[0] = 1'b1; ent[0] = 8'hA0;
    cyc();
    ven = '0;
    chk("t6 pre valid", 32'(validSalida), 1);
    reset = 1'b1;
    ven[3] = 1'b1; ent[3] = 8'hEE;
    cyc();
    exp_q.delete();
    chk_reset_state("t6 midreset");
    reset = 1'b0;
    ven = '0;
    readySalida = 1'b1;
    ven[0] = 1'b1; ent[0] = 8'hD0;
    ven[2] = 1'b1; ent[2] = 8'hD2;
    expect_out(8'hD0, 0);
    expect_out(8'hD2, 2);
    cyc();
    ven = '0;
    chk("t6 no bypass", 32'(validSalida), 0);
    cyc();
    chk("t6 first lane", 32'(laneSalida), 0);
    chk("t6 first data", 32'(Salida), 32'hD0);
    drain("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_arb_4to1.md
MUX_ARB_4TO1 -- requirements
Module: mux_arb_4to1

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the per-lane FIFO depth in bytes (power of two, 2..16).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the data width in bits.
Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge triggered.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports Entrada0..Entrada3, input, WIDTH each, lane input bytes.
REQ-006 The block SHALL have ports validEntrada0..validEntrada3, input, 1 each, lane push strobes.
REQ-007 The block SHALL have ports full0..full3, output, 1 each, lane FIFO holds DEPTH bytes.
REQ-008 The block SHALL have ports overflow0..overflow3, output, 1 each, sticky lane push-while-full flag.
REQ-009 The block SHALL have port Salida, output, WIDTH, merged output byte.
REQ-010 The block SHALL have port validSalida, output, 1, Salida and laneSalida are valid.
REQ-011 The block SHALL have port laneSalida, output, 2, source lane of Salida.
REQ-012 The block SHALL have port readySalida, input, 1, downstream accepts Salida this cycle.

Function
REQ-013 A lane push SHALL occur when validEntradaN=1 and fullN=0 at the clock edge.
REQ-014 A push with fullN=1 SHALL be dropped and SHALL set overflowN, even if the same lane pops in that cycle.
REQ-015 Each lane FIFO SHALL preserve byte order, and its count SHALL stay in 0..DEPTH.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH.
REQ-017 fullN SHALL equal (countN==DEPTH) and SHALL be registered-state derived, with no combinational path from validEntradaN.
REQ-018 The output stage SHALL be a register slice that loads when validSalida=0 or readySalida=1.
REQ-019 On load, the arbiter SHALL grant the first non-empty lane searching from last_grant+1 modulo 4 upward.
REQ-020 On load, the granted FIFO SHALL pop one byte into Salida, laneSalida SHALL take the lane index, validSalida SHALL be 1, and last_grant SHALL update to the granted lane.
REQ-021 On load with all lanes empty, validSalida SHALL become 0 and last_grant SHALL be unchanged.
REQ-022 While validSalida=1 and readySalida=0, Salida, laneSalida and validSalida SHALL hold stable, and no pop SHALL occur.
REQ-023 Latency SHALL be fixed: a byte pushed at edge t into an idle block SHALL appear on Salida with validSalida=1 after edge t+1.
REQ-024 There SHALL be no same-cycle bypass from an empty FIFO.
REQ-025 A simultaneous push and pop on one lane SHALL be permitted when 0<count<DEPTH, leaving the count unchanged.
REQ-026 Sustained throughput SHALL be 1 byte per cycle while any lane is non-empty and readySalida=1.
REQ-027 With all four lanes continuously non-empty, grants SHALL cycle 0,1,2,3,0,...

Reset
REQ-028 While reset=1 at a clock edge, all FIFO counts and pointers SHALL clear to 0.
REQ-029 While reset=1 at a clock edge, Salida SHALL be 0, validSalida 0, laneSalida 0, full0..3 0 and overflow0..3 0.
REQ-030 Reset SHALL set last_grant to 3, so lane 0 has first priority.
REQ-031 Pushes presented while reset=1 SHALL be discarded.
REQ-032 A reset asserted mid-stream SHALL discard all buffered bytes and the pending output byte.
REQ-033 overflowN SHALL clear only on reset.

Structure
REQ-034 A shared package SHALL hold the NUM_LANES=4 constant, the lane-index width (2) and default DEPTH/WIDTH, and SHALL be reused by the downstream demux.
REQ-035 One sub-module, fifo_lane (sync FIFO: push, pop, data in/out, count, full, empty), SHALL be instantiated four times.
REQ-036 Arbiter and output slice SHALL reside in the top level.

Verification
REQ-037 The bench SHALL cover: reset, then push 0xA5 on lane 2 only, readySalida=1 -> Salida=0xA5, laneSalida=2, validSalida=1 two edges after the push, then validSalida=0.
REQ-038 The bench SHALL cover: lanes 0..3 each preloaded with 2 bytes (0x10,0x11 / 0x20,0x21 / 0x30,0x31 / 0x40,0x41), readySalida=1 -> output 0x10,0x20,0x30,0x40,0x11,0x21,0x31,0x41 on consecutive cycles.
REQ-039 The bench SHALL cover: 5 pushes to lane 1 with readySalida=0, DEPTH=4 -> full1=1 after the 4th, 5th byte dropped, overflow1=1, and after release only the first 4 bytes appear in order.
REQ-040 The bench SHALL cover: readySalida=0 for 3 cycles with validSalida=1 -> Salida and laneSalida unchanged, lane counts unchanged except pushes.
REQ-041 The bench SHALL cover: lane 3 at count 2 with simultaneous push and grant -> count stays 2 and FIFO order is preserved.
REQ-042 The bench SHALL cover: reset pulsed while 3 lanes hold data -> all outputs at reset values next cycle, and the first post-reset grant is lane 0 when lanes 0 and 2 are both non-empty.
